// File: rtl/ultrasound_pkg.sv
// Shared definitions for the ultrasound acquisition readout path.
package ultrasound_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        RUN    = 4'b0010,
        DRAIN  = 4'b0100,
        FINISH = 4'b1000
    } state_t;

    localparam int LANE_W = 16;
    localparam int QDEPTH = 4;
    localparam int QPTR_W = $clog2(QDEPTH);
    localparam int QCNT_W = $clog2(QDEPTH + 1);

endpackage

// File: rtl/word_queue.sv
// Small synchronous FIFO holding packed output words plus their last flag.
module word_queue
    import ultrasound_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic [QCNT_W-1:0] count
);

    logic [WIDTH-1:0]  mem [QDEPTH];
    logic [QPTR_W-1:0] rd_ptr, wr_ptr;
    logic              do_push, do_pop;

    assign do_push = push && (count != QCNT_W'(QDEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + QCNT_W'(do_push) - QCNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/echo_fifo_reader.sv
// Drains one echo worth of ADC samples from the sample FIFO and emits them
// two-per-word on a valid/ready stream, aborting if the FIFO stays empty too long.
module echo_fifo_reader
    import ultrasound_pkg::*;
#(
    parameter int DATA_WIDTH     = 12,
    parameter int SAMPLES_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic [SAMPLES_WIDTH-1:0] SAMPLE_COUNT,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR_TIMEOUT,
    output logic                     FIFO_RDREQ,
    input  logic [DATA_WIDTH-1:0]    FIFO_Q,
    input  logic                     FIFO_EMPTY,
    output logic [31:0]              OUT_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     OUT_LAST
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state, state_nxt;
    logic [SAMPLES_WIDTH-1:0] req_rem, cap_rem;
    logic                     rd_pend, half, fin_hold, err;
    logic [LANE_W-1:0]        lo, q_ext;
    logic [TW-1:0]            tmo_cnt;
    logic                     start_acc, starved, abort, issue, push, pop;
    logic [32:0]              push_word, head;
    logic [QCNT_W-1:0]        q_count;

    assign start_acc = START && (state == IDLE);
    assign starved   = (state == RUN) && (req_rem != '0) && FIFO_EMPTY;
    assign abort     = starved && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    // Threshold of 2 leaves room for the word completed by a read still in flight.
    assign issue     = (state == RUN) && (req_rem != '0) && !FIFO_EMPTY
                       && (q_count <= QCNT_W'(2));
    assign pop       = OUT_VALID && OUT_READY;

    // Capture path: the odd sample completes a word; a trailing even sample goes out alone.
    always_comb begin
        q_ext     = LANE_W'(FIFO_Q);
        push      = 1'b0;
        push_word = '0;
        if (rd_pend) begin
            if (half) begin
                push      = 1'b1;
                push_word = {cap_rem == SAMPLES_WIDTH'(1), q_ext, lo};
            end else if (cap_rem == SAMPLES_WIDTH'(1)) begin
                push      = 1'b1;
                push_word = {1'b1, LANE_W'(0), q_ext};
            end
        end
    end

    word_queue #(.WIDTH(33)) u_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .flush     (abort),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .count     (q_count)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (START) state_nxt = (SAMPLE_COUNT == '0) ? FINISH : RUN;
            RUN: begin
                if (abort)                                        state_nxt = FINISH;
                else if (issue && req_rem == SAMPLES_WIDTH'(1))   state_nxt = DRAIN;
            end
            DRAIN:   if (pop && head[32]) state_nxt = FINISH;
            FINISH:  if (!fin_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-length echo spends one busy cycle in FINISH before pulsing DONE.
    assign DONE        = (state == FINISH) && !fin_hold;
    assign BUSY        = (state != IDLE) && !DONE;
    assign FIFO_RDREQ  = issue;
    assign ERR_TIMEOUT = err;
    assign OUT_VALID   = (q_count != '0);
    assign OUT_DATA    = OUT_VALID ? head[31:0] : 32'h0;
    assign OUT_LAST    = OUT_VALID && head[32];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            req_rem  <= '0;
            cap_rem  <= '0;
            rd_pend  <= 1'b0;
            half     <= 1'b0;
            lo       <= '0;
            tmo_cnt  <= '0;
            fin_hold <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_pend  <= issue;
            fin_hold <= 1'b0;
            tmo_cnt  <= starved ? tmo_cnt + TW'(1) : '0;
            if (issue) req_rem <= req_rem - SAMPLES_WIDTH'(1);
            if (rd_pend) begin
                cap_rem <= cap_rem - SAMPLES_WIDTH'(1);
                if (!half) lo <= q_ext;
                half <= !half;
            end
            if (start_acc) begin
                req_rem  <= SAMPLE_COUNT;
                cap_rem  <= SAMPLE_COUNT;
                half     <= 1'b0;
                tmo_cnt  <= '0;
                err      <= 1'b0;
                fin_hold <= (SAMPLE_COUNT == '0);
            end
            if (abort) begin
                err     <= 1'b1;
                rd_pend <= 1'b0;
                half    <= 1'b0;
                req_rem <= '0;
                cap_rem <= '0;
            end
        end
    end

endmodule

// File: tb/tb_echo_fifo_reader.sv
// Directed bench for echo_fifo_reader: FIFO model, packing scoreboard, literal pins.
module tb_echo_fifo_reader;
    localparam int DW = 12;
    localparam int SW = 32;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1, START = 1'b0, OUT_READY = 1'b1;
    logic [SW-1:0] SAMPLE_COUNT = '0;
    logic          BUSY, DONE, ERR_TIMEOUT, FIFO_RDREQ, FIFO_EMPTY, OUT_VALID, OUT_LAST;
    logic [DW-1:0] FIFO_Q = '0;
    logic [31:0]   OUT_DATA;

    int errors = 0, checks = 0;
    logic [DW-1:0] fmem [0:511];
    int frd = 0, fwr = 0;
    logic [32:0] exp_mem [0:255];
    int exp_wr = 0, exp_rd = 0;
    logic [32:0] acc_mem [0:255];
    int acc_n = 0, done_cnt = 0, rdreq_cnt = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [32:0] pw = '0;

    echo_fifo_reader #(.DATA_WIDTH(DW), .SAMPLES_WIDTH(SW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SAMPLE_COUNT(SAMPLE_COUNT),
        .BUSY(BUSY), .DONE(DONE), .ERR_TIMEOUT(ERR_TIMEOUT), .FIFO_RDREQ(FIFO_RDREQ),
        .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY), .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST)
    );

    always #5 CLK = ~CLK;

    // External sample FIFO, normal mode: data appears the cycle after the request.
    assign FIFO_EMPTY = (frd == fwr);
    always @(posedge CLK) begin
        if (FIFO_RDREQ && frd != fwr) begin
            FIFO_Q <= fmem[frd];
            frd    <= frd + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the scoreboard plus stream/read-issue rules.
    always @(negedge CLK) begin
        if (FIFO_RDREQ) begin
            rdreq_cnt++;
            check("rdreq_while_empty", FIFO_EMPTY, 0);
            checks++;
            if (dut.u_queue.count > 2) begin
                errors++;
                $display("FAIL rdreq_queue_count: got %0d expected <=2", dut.u_queue.count);
            end
        end
        if (DONE) done_cnt++;
        if (pv && !pr && OUT_VALID) check("stall_hold", {OUT_LAST, OUT_DATA}, pw);
        if (OUT_VALID && OUT_READY) begin
            acc_mem[acc_n] = {OUT_LAST, OUT_DATA};
            acc_n++;
            if (exp_rd == exp_wr) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", {OUT_LAST, OUT_DATA});
            end else begin
                check("word", {OUT_LAST, OUT_DATA}, exp_mem[exp_rd]);
                exp_rd++;
            end
        end
        pv = OUT_VALID;
        pr = OUT_READY;
        pw = {OUT_LAST, OUT_DATA};
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fpush(input logic [DW-1:0] v);
        fmem[fwr] = v;
        fwr++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  BUSY, 0);
        check({tag, "_done"},  DONE, 0);
        check({tag, "_err"},   ERR_TIMEOUT, 0);
        check({tag, "_rdreq"}, FIFO_RDREQ, 0);
        check({tag, "_valid"}, OUT_VALID, 0);
        check({tag, "_last"},  OUT_LAST, 0);
        check({tag, "_data"},  OUT_DATA, 0);
    endtask

    // Start an echo of n samples and wait for DONE; returns cycle of DONE after START.
    task automatic start_and_wait(input int n, input bit rnd_ready, output int done_cyc);
        bit got = 0;
        done_cyc = -1;
        SAMPLE_COUNT = n;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 1; c < 3000 && !got; c++) begin
            @(negedge CLK);
            if (DONE) begin
                got = 1;
                done_cyc = c;
            end else begin
                tick();
                if (rnd_ready) OUT_READY = 1'($urandom_range(0, 1));
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_wait: got no DONE expected DONE within 3000 cycles");
        end
    endtask

    // Expected words come from the next n samples the FIFO model will hand out.
    task automatic run_echo(input string tag, input int n, input bit rnd_ready);
        int r0, d0, a0, dc;
        logic [15:0] lo, hi;
        for (int i = 0; i < n; i += 2) begin
            lo = 16'(fmem[frd + i]);
            hi = (i + 1 < n) ? 16'(fmem[frd + i + 1]) : 16'h0;
            exp_mem[exp_wr] = {(i + 2 >= n), hi, lo};
            exp_wr++;
        end
        r0 = rdreq_cnt; d0 = done_cnt; a0 = acc_n;
        start_and_wait(n, rnd_ready, dc);
        check({tag, "_busy_at_done"}, BUSY, 0);
        OUT_READY = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        check({tag, "_rdreq_count"}, rdreq_cnt - r0, n);
        check({tag, "_word_count"},  acc_n - a0, (n + 1) / 2);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_all_words"},   exp_wr - exp_rd, 0);
        check({tag, "_err"},         ERR_TIMEOUT, 0);
    endtask

    initial begin
        int a0, r0, d0, dc;
        repeat (3) tick();
        @(negedge CLK);
        check_reset_outputs("reset");
        tick();
        RESET = 1'b0;

        // 8 samples 1..8, always ready
        for (int i = 1; i <= 8; i++) fpush(DW'(i));
        a0 = acc_n;
        run_echo("t8", 8, 0);
        check("t8_w0", acc_mem[a0],     {1'b0, 32'h0002_0001});
        check("t8_w1", acc_mem[a0 + 1], {1'b0, 32'h0004_0003});
        check("t8_w3", acc_mem[a0 + 3], {1'b1, 32'h0008_0007});

        // odd count: 0xA..0xE
        for (int i = 10; i <= 14; i++) fpush(DW'(i));
        a0 = acc_n;
        run_echo("t5", 5, 0);
        check("t5_w0", acc_mem[a0],     {1'b0, 32'h000B_000A});
        check("t5_w2", acc_mem[a0 + 2], {1'b1, 32'h0000_000E});

        // 64 random samples with backpressure
        for (int i = 0; i < 64; i++) fpush(DW'($urandom_range(0, 4095)));
        run_echo("t64", 64, 1);

        // zero-length echo
        r0 = rdreq_cnt; a0 = acc_n; d0 = done_cnt;
        SAMPLE_COUNT = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        @(negedge CLK);
        check("t0_c1_busy", BUSY, 1);
        check("t0_c1_done", DONE, 0);
        @(negedge CLK);
        check("t0_c2_done", DONE, 1);
        check("t0_c2_busy", BUSY, 0);
        repeat (3) tick();
        @(negedge CLK);
        check("t0_rdreq", rdreq_cnt - r0, 0);
        check("t0_words", acc_n - a0, 0);
        check("t0_done_pulses", done_cnt - d0, 1);

        // timeout: 4 requested, only 2 available
        fpush(12'h111);
        fpush(12'h222);
        exp_mem[exp_wr] = {1'b0, 32'h0222_0111};
        exp_wr++;
        r0 = rdreq_cnt; a0 = acc_n;
        start_and_wait(4, 0, dc);
        check("tmo_done_cycle", dc, 19);
        check("tmo_err", ERR_TIMEOUT, 1);
        check("tmo_valid", OUT_VALID, 0);
        repeat (3) tick();
        @(negedge CLK);
        check("tmo_err_sticky", ERR_TIMEOUT, 1);
        check("tmo_words", acc_n - a0, 1);
        check("tmo_rdreq", rdreq_cnt - r0, 2);
        exp_wr = exp_rd;
        fpush(12'h333);
        fpush(12'h444);
        SAMPLE_COUNT = 2;
        START = 1'b1;
        exp_mem[exp_wr] = {1'b1, 32'h0444_0333};
        exp_wr++;
        tick();
        START = 1'b0;
        @(negedge CLK);
        check("tmo_err_cleared", ERR_TIMEOUT, 0);
        for (int c = 0; c < 50 && BUSY; c++) @(negedge CLK);
        repeat (3) tick();
        check("tmo_next_words", exp_wr - exp_rd, 0);

        // reset mid-RUN with 2 words queued
        for (int i = 0; i < 16; i++) fpush(DW'(12'h100 + i));
        OUT_READY = 1'b0;
        SAMPLE_COUNT = 16;
        START = 1'b1;
        tick();
        START = 1'b0;
        begin
            bit seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge CLK);
                if (dut.u_queue.count == 2) seen = 1;
            end
            check("rst_two_queued", seen, 1);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midrst");
        exp_wr = exp_rd;
        OUT_READY = 1'b1;
        run_echo("after_rst", 4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
